sap1_control_matrix: RTL and testbench
======================================

// Module: sap1_control_matrix
// PURPOSE
//  Controller-sequencer consuming the 6-bit one-hot T-state ring (T1..T6) and the IR opcode.
//  Decodes both into the 12-bit SAP-1 control word CON.
//  Sequential duties: HLT latch, ring-sequence supervisor, illegal-opcode flag, retired-instruction counter.
//  Sits between the ring counter/IR and every bus-driving or loading register (PC, MAR, RAM, IR, A, B, ALU, OUT).
// PARAMETERS
//  CNT_W      8    width of the retired-instruction counter
//  CHECK_SEQ  1    1 = ring-sequence supervisor enabled; 0 = seq_err tied 0
// PORTS
//  clk        in   1      system clock; all state updates on posedge (ring advances on negedge)
//  clr_n      in   1      reset, asynchronous, active-low
//  t_state    in   6      one-hot T-state from ring counter; bit0 = T1 .. bit5 = T6
//  opcode     in   4      IR upper nibble
//  con        out  12     {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//  hlt        out  1      halted, sticky until clr_n
//  seq_err    out  1      ring sequence fault, sticky
//  op_err     out  1      illegal opcode seen in execute phase, sticky
//  instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (clr_n=0, async): hlt=0, seq_err=0, op_err=0, instr_cnt=0, supervisor expects T1. con follows decode.
//  con is combinational from t_state/opcode; zero latency. Consumers load on the next posedge.
//  IDLE = 12'h3E3 (all actives deasserted).
//  Fetch, any opcode: T1=5E3 (Ep,Lm_n) | T2=BE3 (Cp) | T3=263 (CE_n,Li_n).
//  LDA 4'h0: T4=1A3 | T5=2C3 | T6=3E3.
//  ADD 4'h1: T4=1A3 | T5=2E1 | T6=3C7.
//  SUB 4'h2: T4=1A3 | T5=2E1 | T6=3CF (Su).
//  OUT 4'hE: T4=3F2 | T5=3E3 | T6=3E3.
//  HLT 4'hF: T4..T6 = IDLE.
//  Illegal opcode: T4..T6 = IDLE; op_err set on posedge during T4.
//  t_state not one-hot (zero or >1 bit set): con=IDLE.
//  Force: con=IDLE whenever hlt=1 or seq_err=1; overrides all decode.
//  HLT latch: set on posedge when t_state=T4 and opcode=4'hF. Cleared only by clr_n.
//   - Effective from the next cycle: T4 of HLT already outputs IDLE, so no glitch.
//  Supervisor (CHECK_SEQ=1): samples t_state each posedge and compares with expected.
//   - Expected = T1 after reset, else previous sample rotated left (T6 -> T1).
//   - Mismatch or non-one-hot -> seq_err=1 (sticky).
//   - While hlt=1 the ring keeps rotating and is still checked.
//  instr_cnt: +1 on posedge with t_state=T6, hlt=0, seq_err=0.
//   - HLT is never counted (hlt already set at its T6).
//   - Illegal opcodes are counted. 2^CNT_W-1 -> 0.
//  Simultaneous events: op_err and hlt cannot coincide (HLT is legal).
//   - seq_err and instr_cnt increment on the same edge: the increment is suppressed.
//  Reset mid-instruction: all sticky state clears immediately.
//   - Ring must be re-cleared to T1 in the same window (system drives ring clr = ~clr_n), else seq_err at first posedge.
// STRUCTURE
//  sap1_pkg: opcode localparams (OP_LDA/ADD/SUB/OUT/HLT), CON bit indices, CON_IDLE/CON_T1..T3 and per-op execute words.
//  Sub-module sap1_seq_checker: one-hot check + expected-state register + seq_err latch.
//  Decode, HLT latch and counter stay in the top.
// TESTING
//  1. clr_n pulse low, then LDA (op 0) through T1..T6 -> con 5E3,BE3,263,1A3,2C3,3E3; instr_cnt=1.
//  2. ADD then SUB -> T5=2E1 both; T6=3C7 then 3CF; instr_cnt=2; no flags.
//  3. OUT, then HLT -> OUT T4=3F2. HLT: hlt=1 after its T4 edge; con=3E3 for 12 more cycles; instr_cnt frozen at 1.
//  4. Opcode 4'h5 -> con=3E3 in T4..T6; op_err=1 from the T4 edge; instr_cnt increments; next fetch normal.
//  5. Inject t_state T2 -> T4 skip, or 6'b000011 -> seq_err=1 same edge; con=3E3 thereafter.
//     With CHECK_SEQ=0 -> no flag.
//  6. clr_n low mid-T5 with hlt/op_err/seq_err set, CNT_W=2 after 4 retires:
//     -> all flags 0 and instr_cnt=0 immediately (async).
//     Also check wrap 3 -> 0 before the reset.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encodings, control-word bit positions
// and the constant control words used by the decoder.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  // Bit positions inside con = {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam int CON_CP   = 11;
  localparam int CON_EP   = 10;
  localparam int CON_LM_N = 9;
  localparam int CON_CE_N = 8;
  localparam int CON_LI_N = 7;
  localparam int CON_EI_N = 6;
  localparam int CON_LA_N = 5;
  localparam int CON_EA   = 4;
  localparam int CON_SU   = 3;
  localparam int CON_EU   = 2;
  localparam int CON_LB_N = 1;
  localparam int CON_LO_N = 0;

  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEM_T4 = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_LDA_T6 = 12'h3E3;
  localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

  function automatic logic is_one_hot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

  // Pure decode of ring state and opcode; halt/fault forcing is applied by the caller.
  function automatic logic [11:0] decode(input logic [5:0] ts, input logic [3:0] op);
    logic [11:0] w;
    w = CON_IDLE;
    case (ts)
      T1: w = CON_T1;
      T2: w = CON_T2;
      T3: w = CON_T3;
      T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: w = CON_MEM_T4;
          OP_OUT:                 w = CON_OUT_T4;
          default:                w = CON_IDLE;
        endcase
      end
      T5: begin
        case (op)
          OP_LDA:         w = CON_LDA_T5;
          OP_ADD, OP_SUB: w = CON_ALU_T5;
          default:        w = CON_IDLE;
        endcase
      end
      T6: begin
        case (op)
          OP_LDA:  w = CON_LDA_T6;
          OP_ADD:  w = CON_ADD_T6;
          OP_SUB:  w = CON_SUB_T6;
          default: w = CON_IDLE;
        endcase
      end
      default: w = CON_IDLE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sap1_seq_checker.sv
// Ring-sequence supervisor: tracks the T-state the ring should present next
// and latches a sticky fault on any deviation or non-one-hot sample.
module sap1_seq_checker
  import sap1_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] t_state,
  output logic       fault,
  output logic       seq_err,
  output logic [5:0] expected
);

  generate
    if (ENABLE) begin : g_check
      logic [5:0] exp_q;
      logic       err_q;

      // fault is this cycle's verdict so the top can suppress same-edge side effects
      assign fault    = !is_one_hot(t_state) || (t_state != exp_q);
      assign seq_err  = err_q;
      assign expected = exp_q;

      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          exp_q <= T1;
          err_q <= 1'b0;
        end else begin
          exp_q <= {t_state[4:0], t_state[5]};
          if (fault) err_q <= 1'b1;
        end
      end
    end else begin : g_off
      assign fault    = 1'b0;
      assign seq_err  = 1'b0;
      assign expected = T1;
    end
  endgenerate

endmodule

// File: rtl/sap1_control_matrix.sv
// SAP-1 controller-sequencer: decodes ring state and opcode into the control word,
// and keeps the halt latch, illegal-opcode flag and retired-instruction counter.
module sap1_control_matrix
  import sap1_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [5:0]       t_state,
  input  logic [3:0]       opcode,
  output logic [11:0]      con,
  output logic             hlt,
  output logic             seq_err,
  output logic             op_err,
  output logic [CNT_W-1:0] instr_cnt
);

  logic       seq_fault;
  logic [5:0] seq_expected;

  sap1_seq_checker #(
    .ENABLE (CHECK_SEQ)
  ) u_seq_checker (
    .clk      (clk),
    .clr_n    (clr_n),
    .t_state  (t_state),
    .fault    (seq_fault),
    .seq_err  (seq_err),
    .expected (seq_expected)
  );

  // Halt or a ring fault parks every register; decode is bypassed entirely.
  always_comb begin
    con = decode(t_state, opcode);
    if (hlt || seq_err) con = CON_IDLE;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hlt       <= 1'b0;
      op_err    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if ((t_state == T4) && (opcode == OP_HLT)) hlt <= 1'b1;
      if ((t_state == T4) && !is_legal(opcode))  op_err <= 1'b1;
      // A fault detected on this very edge also blocks the retire.
      if ((t_state == T6) && !hlt && !seq_err && !seq_fault)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  logic unused_dbg;
  assign unused_dbg = ^seq_expected;

endmodule

// File: tb/tb_sap1_control_matrix.sv
// Directed bench for sap1_control_matrix: default build, supervisor-off build
// and a 2-bit counter build share one clock, reset and input stream.
module tb_sap1_control_matrix;

  logic        clk;
  logic        clr_n;
  logic [5:0]  t_state;
  logic [3:0]  opcode;

  logic [11:0] con_a, con_b, con_c;
  logic        hlt_a, hlt_b, hlt_c;
  logic        seq_a, seq_b, seq_c;
  logic        ope_a, ope_b, ope_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                         S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sap1_control_matrix dut_a (
    .clk(clk), .clr_n(clr_n), .t_state(t_state), .opcode(opcode),
    .con(con_a), .hlt(hlt_a), .seq_err(seq_a), .op_err(ope_a), .instr_cnt(cnt_a)
  );

  sap1_control_matrix #(.CHECK_SEQ(1'b0)) dut_b (
    .clk(clk), .clr_n(clr_n), .t_state(t_state), .opcode(opcode),
    .con(con_b), .hlt(hlt_b), .seq_err(seq_b), .op_err(ope_b), .instr_cnt(cnt_b)
  );

  sap1_control_matrix #(.CNT_W(2)) dut_c (
    .clk(clk), .clr_n(clr_n), .t_state(t_state), .opcode(opcode),
    .con(con_c), .hlt(hlt_c), .seq_err(seq_c), .op_err(ope_c), .instr_cnt(cnt_c)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic hold_reset();
    @(negedge clk);
    clr_n   = 1'b0;
    t_state = S1;
    opcode  = 4'h0;
    repeat (2) @(posedge clk);
  endtask

  // Release shortly after a posedge so the next edge samples T1.
  task automatic release_reset();
    @(posedge clk);
    #2 clr_n = 1'b1;
  endtask

  task automatic drive(input logic [5:0] ts, input logic [3:0] op, input logic [11:0] exp_con);
    @(negedge clk);
    t_state = ts;
    opcode  = op;
    #1 check("con", 32'(con_a), 32'(exp_con));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [11:0] c6);
    drive(S1, op, 12'h5E3);
    drive(S2, op, 12'hBE3);
    drive(S3, op, 12'h263);
    drive(S4, op, c4);
    drive(S5, op, c5);
    drive(S6, op, c6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ring;
    clr_n   = 1'b0;
    t_state = S1;
    opcode  = 4'h0;

    // Reset values and decode while held in reset
    hold_reset();
    #1;
    check("rst_hlt", 32'(hlt_a), 32'd0);
    check("rst_seq", 32'(seq_a), 32'd0);
    check("rst_op",  32'(ope_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_con", 32'(con_a), 32'h5E3);
    release_reset();

    // LDA
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    check("lda_cnt", 32'(cnt_a), 32'd1);

    // ADD then SUB
    run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    check("alu_cnt", 32'(cnt_a), 32'd3);
    check("alu_seq", 32'(seq_a), 32'd0);
    check("alu_op",  32'(ope_a), 32'd0);
    check("alu_hlt", 32'(hlt_a), 32'd0);

    // Illegal opcode 5: idle execute, op_err from T4 edge, still retired
    drive(S1, 4'h5, 12'h5E3);
    drive(S2, 4'h5, 12'hBE3);
    drive(S3, 4'h5, 12'h263);
    check("ill_op_pre", 32'(ope_a), 32'd0);
    drive(S4, 4'h5, 12'h3E3);
    check("ill_op_t4", 32'(ope_a), 32'd1);
    drive(S5, 4'h5, 12'h3E3);
    drive(S6, 4'h5, 12'h3E3);
    check("ill_cnt", 32'(cnt_a), 32'd4);
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    check("ill_next_cnt", 32'(cnt_a), 32'd5);

    // OUT then HLT
    run_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
    check("out_cnt", 32'(cnt_a), 32'd6);
    drive(S1, 4'hF, 12'h5E3);
    drive(S2, 4'hF, 12'hBE3);
    drive(S3, 4'hF, 12'h263);
    check("hlt_pre", 32'(hlt_a), 32'd0);
    drive(S4, 4'hF, 12'h3E3);
    check("hlt_set", 32'(hlt_a), 32'd1);
    ring = S5;
    for (int i = 0; i < 12; i++) begin
      drive(ring, 4'hF, 12'h3E3);
      ring = {ring[4:0], ring[5]};
    end
    check("hlt_cnt", 32'(cnt_a), 32'd6);
    check("hlt_seq", 32'(seq_a), 32'd0);
    check("hlt_hold", 32'(hlt_a), 32'd1);

    // Ring skip T2 -> T4
    hold_reset();
    release_reset();
    drive(S1, 4'h0, 12'h5E3);
    drive(S2, 4'h0, 12'hBE3);
    drive(S4, 4'h0, 12'h1A3);
    check("skip_seq_a", 32'(seq_a), 32'd1);
    check("skip_seq_b", 32'(seq_b), 32'd0);
    drive(S5, 4'h0, 12'h3E3);
    check("skip_con_b", 32'(con_b), 32'h2C3);
    drive(S6, 4'h0, 12'h3E3);
    check("skip_cnt_a", 32'(cnt_a), 32'd0);
    check("skip_cnt_b", 32'(cnt_b), 32'd1);

    // Non-one-hot ring value
    hold_reset();
    release_reset();
    drive(S1, 4'h0, 12'h5E3);
    drive(6'b000011, 4'h0, 12'h3E3);
    check("nonhot_seq_a", 32'(seq_a), 32'd1);
    check("nonhot_seq_b", 32'(seq_b), 32'd0);

    // Counter wrap on the 2-bit build, then async reset mid-T5 with all flags set
    hold_reset();
    release_reset();
    for (int i = 0; i < 3; i++) run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    check("wrap_cnt3", 32'(cnt_c), 32'd3);
    drive(S1, 4'h5, 12'h5E3);
    drive(S2, 4'h5, 12'hBE3);
    drive(S3, 4'h5, 12'h263);
    drive(S4, 4'h5, 12'h3E3);
    drive(S5, 4'h5, 12'h3E3);
    drive(S6, 4'h5, 12'h3E3);
    check("wrap_cnt0", 32'(cnt_c), 32'd0);
    check("wrap_cnt_a", 32'(cnt_a), 32'd4);
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    drive(S1, 4'hF, 12'h5E3);
    drive(S2, 4'hF, 12'hBE3);
    drive(S3, 4'hF, 12'h263);
    drive(S4, 4'hF, 12'h3E3);
    drive(S5, 4'hF, 12'h3E3);
    drive(S6, 4'hF, 12'h3E3);
    drive(S1, 4'hF, 12'h3E3);
    drive(S3, 4'hF, 12'h3E3);
    check("pre_rst_hlt", 32'(hlt_c), 32'd1);
    check("pre_rst_op",  32'(ope_c), 32'd1);
    check("pre_rst_seq", 32'(seq_c), 32'd1);
    check("pre_rst_cnt", 32'(cnt_c), 32'd1);

    @(negedge clk);
    t_state = S5;
    opcode  = 4'hF;
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_hlt", 32'(hlt_c), 32'd0);
    check("mid_rst_op",  32'(ope_c), 32'd0);
    check("mid_rst_seq", 32'(seq_c), 32'd0);
    check("mid_rst_cnt", 32'(cnt_c), 32'd0);
    check("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
    t_state = S1;
    opcode  = 4'h0;
    release_reset();
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    check("post_rst_cnt", 32'(cnt_c), 32'd1);
    check("post_rst_seq", 32'(seq_c), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
